// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the seven-segment display scan path.
//   SSD_NUM_DIGITS : number of anodes on the display
//   SSD_CTRL_OFF   : active-low enable pattern with every digit dark
//   ssd_idx_t      : 2-bit digit index (digit 0 = least significant)
//   ssd_ctrl_sel() : one-hot-low anode enable for a digit index
package ssd_pkg;

  localparam int SSD_NUM_DIGITS = 4;
  localparam logic [SSD_NUM_DIGITS-1:0] SSD_CTRL_OFF = 4'b1111;

  typedef logic [1:0] ssd_idx_t;

  // Bit k low lights digit k; all other anodes stay off.
  function automatic logic [SSD_NUM_DIGITS-1:0] ssd_ctrl_sel(input ssd_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/ssd_refresh_tick.sv
// ssd_refresh_tick: free-running prescaler producing a one-cycle tick every
// REFRESH_DIV clocks.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (prescaler returns to 0)
//   tick  out high during the last count of each REFRESH_DIV-cycle period
module ssd_refresh_tick #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // With REFRESH_DIV = 1 the counter is a single bit pinned at 0, so the
  // compare below is permanently true and tick fires every cycle.
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick     = (cnt_reg == CNT_LAST);
  assign cnt_next = tick ? '0 : cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: time-multiplexes a 4-digit BCD word onto one BCD nibble and
// drives the matching active-low anode enables. The word is latched into a
// shadow register once per frame so a frame is never torn.
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   digits_in  in  [15:12] digit 3 (MSD) .. [3:0] digit 0
//   blank_lz   in  1 = suppress leading zeros
//   bcd_out    out BCD nibble of the digit currently lit
//   ctrl       out one-hot-low anode enable, 4'b1111 when dark
//   frame_done out one-cycle pulse when a new frame word is captured
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic        blank_lz,
  output logic [3:0]  bcd_out,
  output logic [3:0]  ctrl,
  output logic        frame_done
);

  logic tick;

  ssd_refresh_tick #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  ssd_idx_t                  idx_reg;
  ssd_idx_t                  idx_next;
  logic [15:0]               shadow_word_reg;
  logic                      shadow_blank_reg;
  logic [3:0]                bcd_reg;
  logic [SSD_NUM_DIGITS-1:0] ctrl_reg;
  logic                      frame_done_reg;

  logic                      capture;
  logic [15:0]               word_sel;
  logic                      blank_sel;
  logic [3:0]                word_digit [SSD_NUM_DIGITS];
  logic [SSD_NUM_DIGITS-1:0] digit_blanked;

  assign idx_next = idx_reg + 2'd1;

  // The 3->0 transition starts a frame. The update on that same edge must
  // show the freshly captured word, so the display path reads digits_in
  // directly instead of the shadow that is only being written now.
  assign capture   = tick && (idx_reg == 2'd3);
  assign word_sel  = capture ? digits_in : shadow_word_reg;
  assign blank_sel = capture ? blank_lz  : shadow_blank_reg;

  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 is never blanked so an all-zero word still shows "0".
  // Nibbles A-F are non-zero and stop the chain.
  genvar gi;
  generate
    for (gi = 0; gi < SSD_NUM_DIGITS; gi++) begin : g_digit
      assign word_digit[gi] = word_sel[gi*4 +: 4];
      if (gi == 0) begin : g_lsd
        assign digit_blanked[gi] = 1'b0;
      end else if (gi == SSD_NUM_DIGITS - 1) begin : g_msd
        assign digit_blanked[gi] = blank_sel && (word_digit[gi] == 4'h0);
      end else begin : g_mid
        assign digit_blanked[gi] = digit_blanked[gi+1] && (word_digit[gi] == 4'h0);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg          <= 2'd3;
      shadow_word_reg  <= 16'h0000;
      shadow_blank_reg <= 1'b0;
      bcd_reg          <= 4'h0;
      ctrl_reg         <= SSD_CTRL_OFF;
      frame_done_reg   <= 1'b0;
    end else begin
      frame_done_reg <= capture;
      if (tick) begin
        idx_reg  <= idx_next;
        // bcd carries the value even when the anode is dark.
        bcd_reg  <= word_digit[idx_next];
        ctrl_reg <= digit_blanked[idx_next] ? SSD_CTRL_OFF : ssd_ctrl_sel(idx_next);
      end
      if (capture) begin
        shadow_word_reg  <= digits_in;
        shadow_blank_reg <= blank_lz;
      end
    end
  end

  assign bcd_out    = bcd_reg;
  assign ctrl       = ctrl_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed bench for ssd_scan_mux: a REFRESH_DIV = 4 instance for the main
// scenarios and a REFRESH_DIV = 1 instance sharing the same inputs.
module tb_ssd_scan_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic [3:0]  ctrl;
  logic        frame_done;
  logic [3:0]  bcd_out1;
  logic [3:0]  ctrl1;
  logic        frame_done1;

  int n_asserts = 0;
  int n_fail    = 0;

  ssd_scan_mux #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .blank_lz  (blank_lz),
    .bcd_out   (bcd_out),
    .ctrl      (ctrl),
    .frame_done(frame_done)
  );

  ssd_scan_mux #(.REFRESH_DIV(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .blank_lz  (blank_lz),
    .bcd_out   (bcd_out1),
    .ctrl      (ctrl1),
    .frame_done(frame_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Main instance: check the full output triple at once.
  task automatic chk_out(input string tag, input logic [3:0] eb, input logic [3:0] ec,
                         input logic ef);
    chk({tag, ".bcd"}, bcd_out, eb);
    chk({tag, ".ctrl"}, ctrl, ec);
    chk({tag, ".fd"}, {3'b0, frame_done}, {3'b0, ef});
    $display("t=%0t %s bcd=%h ctrl=%b fd=%b", $time, tag, bcd_out, ctrl, frame_done);
  endtask

  task automatic chk_out1(input string tag, input logic [3:0] eb, input logic [3:0] ec,
                          input logic ef);
    chk({tag, ".bcd"}, bcd_out1, eb);
    chk({tag, ".ctrl"}, ctrl1, ec);
    chk({tag, ".fd"}, {3'b0, frame_done1}, {3'b0, ef});
    $display("t=%0t %s bcd=%h ctrl=%b fd=%b", $time, tag, bcd_out1, ctrl1, frame_done1);
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] scan_bcd  [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] scan_ctrl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    rst_n     = 1'b1;
    digits_in = 16'h1234;
    blank_lz  = 1'b0;

    // Reset values while held in reset.
    #1 rst_n = 1'b0;
    #1;
    chk_out("reset", 4'h0, 4'b1111, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset_held", 4'h0, 4'b1111, 1'b0);

    // Release: first capture on the 4th edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    adv(3);
    chk_out("post_rst_wait", 4'h0, 4'b1111, 1'b0);
    adv(1);
    chk_out("first_capture", 4'h4, 4'b1110, 1'b1);

    // Two full frames of 1234; each slot held exactly 4 clocks.
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        if (!(f == 0 && k == 0)) begin
          chk_out($sformatf("scan_f%0d_s%0d", f, k), scan_bcd[k], scan_ctrl[k], (k == 0));
        end
        for (int h = 1; h < 4; h++) begin
          adv(1);
          chk_out($sformatf("hold_f%0d_s%0d_c%0d", f, k, h), scan_bcd[k], scan_ctrl[k], 1'b0);
        end
        adv(1);
      end
    end

    // Now at slot 0 of frame 3 (word 1234). Tear-free update.
    chk_out("tear_s0", 4'h4, 4'b1110, 1'b1);
    adv(4);
    chk_out("tear_s1", 4'h3, 4'b1101, 1'b0);
    digits_in = 16'h5678;
    adv(4);
    chk_out("tear_s2", 4'h2, 4'b1011, 1'b0);
    adv(4);
    chk_out("tear_s3", 4'h1, 4'b0111, 1'b0);
    adv(4);
    chk_out("new_s0", 4'h8, 4'b1110, 1'b1);
    adv(4);
    chk_out("new_s1", 4'h7, 4'b1101, 1'b0);
    adv(4);
    chk_out("new_s2", 4'h6, 4'b1011, 1'b0);
    adv(4);
    chk_out("new_s3", 4'h5, 4'b0111, 1'b0);

    // Blanking 0050.
    digits_in = 16'h0050;
    blank_lz  = 1'b1;
    adv(4);
    chk_out("blk0050_s0", 4'h0, 4'b1110, 1'b1);
    adv(4);
    chk_out("blk0050_s1", 4'h5, 4'b1101, 1'b0);
    adv(4);
    chk_out("blk0050_s2", 4'h0, 4'b1111, 1'b0);
    adv(4);
    chk_out("blk0050_s3", 4'h0, 4'b1111, 1'b0);

    // Blanking 0000: only digit 0 lit.
    digits_in = 16'h0000;
    adv(4);
    chk_out("blk0000_s0", 4'h0, 4'b1110, 1'b1);
    adv(4);
    chk_out("blk0000_s1", 4'h0, 4'b1111, 1'b0);
    adv(4);
    chk_out("blk0000_s2", 4'h0, 4'b1111, 1'b0);
    adv(4);
    chk_out("blk0000_s3", 4'h0, 4'b1111, 1'b0);

    // Blanking 0A00: A is non-zero, so only digit 3 goes dark.
    digits_in = 16'h0A00;
    adv(4);
    chk_out("blk0A00_s0", 4'h0, 4'b1110, 1'b1);
    adv(4);
    chk_out("blk0A00_s1", 4'h0, 4'b1101, 1'b0);
    adv(4);
    chk_out("blk0A00_s2", 4'hA, 4'b1011, 1'b0);
    adv(4);
    chk_out("blk0A00_s3", 4'h0, 4'b1111, 1'b0);

    // Async reset mid-frame during digit 2.
    digits_in = 16'h1234;
    blank_lz  = 1'b0;
    adv(4);
    chk_out("pre_rst_s0", 4'h4, 4'b1110, 1'b1);
    adv(4);
    chk_out("pre_rst_s1", 4'h3, 4'b1101, 1'b0);
    adv(4);
    chk_out("pre_rst_s2", 4'h2, 4'b1011, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 4'h0, 4'b1111, 1'b0);
    chk_out1("async_rst_div1", 4'h0, 4'b1111, 1'b0);
    rst_n = 1'b1;

    // After release: div-4 instance waits 4 edges; div-1 instance captures
    // on the first edge and then steps one digit per clock.
    adv(1);
    chk_out("rel_c1", 4'h0, 4'b1111, 1'b0);
    chk_out1("div1_c1", 4'h4, 4'b1110, 1'b1);
    adv(1);
    chk_out("rel_c2", 4'h0, 4'b1111, 1'b0);
    chk_out1("div1_c2", 4'h3, 4'b1101, 1'b0);
    adv(1);
    chk_out("rel_c3", 4'h0, 4'b1111, 1'b0);
    chk_out1("div1_c3", 4'h2, 4'b1011, 1'b0);
    adv(1);
    chk_out("rel_capture", 4'h4, 4'b1110, 1'b1);
    chk_out1("div1_c4", 4'h1, 4'b0111, 1'b0);
    adv(1);
    chk_out1("div1_c5", 4'h4, 4'b1110, 1'b1);
    chk_out("rel_hold", 4'h4, 4'b1110, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scan_mux.md
Name: ssd_scan_mux

Overview:
- Upstream stage of the seven-segment decoder. Time-multiplexes a 4-digit BCD word onto the decoder's single 4-bit BCD input.
- Generates the matching active-low digit-enable (ctrl) pattern for the 4-anode display, so the board shows four digits instead of one.
- Double-buffers the input word at frame boundaries so a frame is never torn.
- Optionally blanks leading zeros.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot. Legal range >= 1. 100 MHz / 100000 gives 1 kHz per digit, 250 Hz per frame.
- CNT_W, max(1, $clog2(REFRESH_DIV)), prescaler width. Derived; not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- digits_in  in  16  four BCD digits. [15:12] is the most significant (digit 3); [3:0] is digit 0.
- blank_lz  in  1  1 = suppress leading zeros.
- bcd_out  out  4  BCD nibble of the active digit; drives the decoder's BCD input.
- ctrl  out  4  active-low digit enable, one-hot-low. Bit k lights digit k.
- frame_done  out  1  one-cycle pulse when a new frame starts and the shadow word is captured.

Behaviour:
- One clock domain. Reset is asynchronous, active-low. All state and all outputs are registered.
- Reset values: prescaler = 0, idx = 3, shadow word = 16'h0000, shadow blank = 0, bcd_out = 4'h0, ctrl = 4'b1111 (all off), frame_done = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1).
  - REFRESH_DIV = 1 gives tick every cycle.
- On tick, idx advances 0->1->2->3->0. There are no other states; idx is a 2-bit wrap counter.
- Frame capture happens on a tick where idx == 3 (the 3->0 transition):
  - shadow word <= digits_in; shadow blank <= blank_lz; frame_done = 1 for that one cycle.
  - Outputs in that same cycle's update use the newly captured digits_in, not the stale shadow.
  - The first tick after reset is therefore a capture, showing digit 0 of live digits_in.
- Output update occurs on every tick, with one register stage. Latency from tick to visible output is 1 clk.
  - bcd_out <= digit[idx_next].
  - ctrl <= ~(4'b0001 << idx_next), or 4'b1111 if that digit is blanked.
- Between ticks, all outputs hold their values. digits_in and blank_lz changes mid-frame have no visible effect until the next capture.
- Leading-zero blanking, evaluated on the captured word with shadow blank = 1:
  - Digit k (k = 3,2,1) is blanked iff digit k and every digit above it equal 4'h0.
  - Digit 0 is never blanked, so 0000 displays "0".
  - bcd_out still carries the digit value while that digit is blanked.
- Non-BCD nibbles (A-F) pass through unchanged, and the decoder renders them as F. They count as non-zero for blanking.
- Reset asserted mid-frame returns every register to its reset value immediately, with no clock needed. The first capture occurs REFRESH_DIV cycles after release.
- No other handshake exists; the block free-runs.

Decomposition:
- Shared package ssd_pkg:
  - SSD_NUM_DIGITS = 4.
  - SSD_CTRL_OFF = 4'b1111.
  - Function ssd_ctrl_sel(idx), returning the one-hot-low pattern.
  - Digit index typedef (2-bit).
- One sub-module, ssd_refresh_tick: parameterised prescaler with outputs tick only, plus clk and rst_n. It is reused by later blink and debounce blocks.
- Blanking logic and shadow registers stay inline.

Test Plan (REFRESH_DIV = 4 in simulation):
- Reset: hold rst_n = 0 with digits_in = 16'h1234. Required: ctrl = 4'b1111, bcd_out = 0, frame_done = 0. Release; 4 cycles later frame_done pulses, then bcd_out = 4, ctrl = 4'b1110.
- Scan: digits_in = 16'h1234, blank_lz = 0, run 2 frames. Required: (bcd_out, ctrl) cycles (4, 1110), (3, 1101), (2, 1011), (1, 0111), each held exactly 4 clk. frame_done occurs once every 16 clk.
- Tear-free: change digits_in from 16'h1234 to 16'h5678 while the digit 1 slot is showing. Required: digits 2 and 3 still show 2 and 1; the next frame shows 8, 7, 6, 5.
- Blanking: blank_lz = 1 with digits_in = 16'h0050. Required: ctrl = 1111 for digit slots 3 and 2; slot 1 shows (5, 1101); slot 0 shows (0, 1110). With 16'h0000, only slot 0 is lit and shows 0. With 16'h0A00, slot 3 is blanked and slot 2 shows A.
- Async reset mid-frame: pulse rst_n low for 1 ns between clock edges during digit 2. Required: outputs go to reset values at once; after release the first update is a capture at digit 0.
- REFRESH_DIV = 1 build: required idx advances every clk and frame_done asserts every 4th clk.
